// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: fixed-priority grant of refresh, write and read clients
// after power-up init, with a per-grant watchdog that forces release and flags an error.
module sdram_arbit #(
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        arb_clk,
    input  logic        arb_rst,

    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank,
    input  logic [12:0] init_addr,

    input  logic        ar_req,
    input  logic        ar_end,
    input  logic [3:0]  ar_cmd,
    input  logic [1:0]  ar_bank,
    input  logic [12:0] ar_addr,

    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [12:0] wr_addr,
    input  logic [15:0] wr_dq,
    input  logic        wr_dq_oe,

    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [12:0] rd_addr,

    output logic        ar_en,
    output logic        wr_en,
    output logic        rd_en,

    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,

    output logic        arb_err
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [1:0]  BANK_NOP = 2'b11;
    localparam logic [12:0] ADDR_NOP = 13'h1fff;

    state_t      state;
    state_t      state_next;
    logic [15:0] wd;
    logic        granted;
    logic        end_hit;
    logic        timeout_hit;

    // End pulses only count for the client that currently owns the bus.
    always_comb begin
        granted = 1'b0;
        end_hit = 1'b0;
        case (state)
            AREF:    begin granted = 1'b1; end_hit = ar_end; end
            WRITE:   begin granted = 1'b1; end_hit = wr_end; end
            READ:    begin granted = 1'b1; end_hit = rd_end; end
            default: begin granted = 1'b0; end_hit = 1'b0;   end
        endcase
        timeout_hit = granted && (wd == (TIMEOUT - 16'd1));
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state   <= INIT;
            wd      <= '0;
            arb_err <= 1'b0;
        end else begin
            state   <= state_next;
            wd      <= granted ? (wd + 16'd1) : '0;
            arb_err <= timeout_hit && !end_hit;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT: begin
                if (init_end)
                    state_next = IDLE;
            end
            IDLE: begin
                if (ar_req)
                    state_next = AREF;
                else if (wr_req)
                    state_next = WRITE;
                else if (rd_req)
                    state_next = READ;
            end
            AREF, WRITE, READ: begin
                if (end_hit || timeout_hit)
                    state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        ar_en        = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        sdram_cmd    = CMD_NOP;
        sdram_ba     = BANK_NOP;
        sdram_addr   = ADDR_NOP;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_bank;
                sdram_addr = init_addr;
            end
            AREF: begin
                ar_en      = 1'b1;
                sdram_cmd  = ar_cmd;
                sdram_ba   = ar_bank;
                sdram_addr = ar_addr;
            end
            WRITE: begin
                wr_en        = 1'b1;
                sdram_cmd    = wr_cmd;
                sdram_ba     = wr_bank;
                sdram_addr   = wr_addr;
                sdram_dq_out = wr_dq;
                sdram_dq_oe  = wr_dq_oe;
            end
            READ: begin
                rd_en      = 1'b1;
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_ba   = BANK_NOP;
                sdram_addr = ADDR_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed scoreboard bench for sdram_arbit: expected per-cycle outputs are queued
// from a small state-based model and compared against the DUT each cycle.
module tb_sdram_arbit;

    logic        clk = 1'b0;
    logic        arb_rst;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [12:0] init_addr;
    logic        ar_req, ar_end;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank;
    logic [12:0] wr_addr;
    logic [15:0] wr_dq;
    logic        wr_dq_oe;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank;
    logic [12:0] rd_addr;
    logic        ar_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        arb_err;

    always #5 clk = ~clk;

    sdram_arbit #(.TIMEOUT(16'd8)) dut (
        .arb_clk(clk), .arb_rst(arb_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .arb_err(arb_err)
    );

    typedef enum {S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ} st_t;

    typedef struct {
        string       tag;
        logic [2:0]  en;
        logic [18:0] bus;
        logic        oe;
        logic [15:0] dq;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string field, input logic [18:0] obs, input logic [18:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "grants", {16'd0, ar_en, wr_en, rd_en}, {16'd0, e.en});
            cmp(e.tag, "cmdbus", {sdram_cmd, sdram_ba, sdram_addr}, e.bus);
            cmp(e.tag, "dq_oe", {18'd0, sdram_dq_oe}, {18'd0, e.oe});
            cmp(e.tag, "dq_out", {3'd0, sdram_dq_out}, {3'd0, e.dq});
            cmp(e.tag, "arb_err", {18'd0, arb_err}, {18'd0, e.err});
        end
    endtask

    // Expected outputs for the cycle, derived from the intended state and the current inputs.
    task automatic expect_cycle(input string tag, input st_t s, input logic err);
        exp_t e;
        e.tag = tag;
        e.err = err;
        e.oe  = 1'b0;
        e.dq  = 16'h0000;
        case (s)
            S_INIT:  begin e.en = 3'b000; e.bus = {init_cmd, init_bank, init_addr}; end
            S_AREF:  begin e.en = 3'b100; e.bus = {ar_cmd, ar_bank, ar_addr}; end
            S_WRITE: begin
                e.en  = 3'b010;
                e.bus = {wr_cmd, wr_bank, wr_addr};
                e.oe  = wr_dq_oe;
                e.dq  = wr_dq;
            end
            S_READ:  begin e.en = 3'b001; e.bus = {rd_cmd, rd_bank, rd_addr}; end
            default: begin e.en = 3'b000; e.bus = {4'b0111, 2'b11, 13'h1fff}; end
        endcase
        sb.push_back(e);
        check_out();
    endtask

    initial begin
        arb_rst  = 1'b1;
        init_end = 1'b0;
        init_cmd = 4'b0010; init_bank = 2'b00; init_addr = 13'h0400;
        ar_req = 1'b0; ar_end = 1'b0; ar_cmd = 4'b0001; ar_bank = 2'b01; ar_addr = 13'h0001;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_bank = 2'b10; wr_addr = 13'h0123;
        wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_bank = 2'b11; rd_addr = 13'h0456;

        tick();
        expect_cycle("reset", S_INIT, 1'b0);
        tick();
        arb_rst = 1'b0;
        expect_cycle("reset_release", S_INIT, 1'b0);

        for (int i = 0; i < 50; i++) begin
            tick();
            expect_cycle("init_hold", S_INIT, 1'b0);
        end
        tick();
        init_end = 1'b1;
        expect_cycle("init_end_seen", S_INIT, 1'b0);
        tick();
        expect_cycle("idle_nop", S_IDLE, 1'b0);

        // init_end dropped once IDLE is reached; all three clients request together.
        init_end = 1'b0;
        ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        expect_cycle("idle_reqs", S_IDLE, 1'b0);
        tick();
        expect_cycle("aref_first", S_AREF, 1'b0);
        tick();
        ar_end = 1'b1; ar_req = 1'b0;
        expect_cycle("aref_end", S_AREF, 1'b0);
        tick();
        ar_end = 1'b0;
        expect_cycle("gap_after_aref", S_IDLE, 1'b0);
        tick();
        expect_cycle("write_data", S_WRITE, 1'b0);
        tick();
        wr_end = 1'b1; wr_req = 1'b0;
        expect_cycle("write_end", S_WRITE, 1'b0);
        tick();
        wr_end = 1'b0;
        expect_cycle("gap_after_write", S_IDLE, 1'b0);
        tick();
        expect_cycle("read_grant", S_READ, 1'b0);
        ar_end = 1'b1;
        expect_cycle("read_ar_end", S_READ, 1'b0);
        tick();
        ar_end = 1'b0;
        expect_cycle("ar_end_ignored", S_READ, 1'b0);
        rd_end = 1'b1; rd_req = 1'b0;
        expect_cycle("read_end", S_READ, 1'b0);
        tick();
        rd_end = 1'b0;
        expect_cycle("idle_after_read", S_IDLE, 1'b0);

        // Watchdog expiry: write granted, never ends.
        wr_req = 1'b1;
        expect_cycle("to_req", S_IDLE, 1'b0);
        tick();
        wr_req = 1'b0;
        expect_cycle("to_write_1", S_WRITE, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            expect_cycle("to_write_n", S_WRITE, 1'b0);
        end
        tick();
        expect_cycle("timeout_err", S_IDLE, 1'b1);
        tick();
        expect_cycle("timeout_err_clear", S_IDLE, 1'b0);

        // End pulse on the same cycle as the watchdog limit.
        wr_req = 1'b1;
        expect_cycle("co_req", S_IDLE, 1'b0);
        tick();
        wr_req = 1'b0;
        expect_cycle("co_write_1", S_WRITE, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            tick();
            expect_cycle("co_write_n", S_WRITE, 1'b0);
        end
        tick();
        wr_end = 1'b1;
        expect_cycle("co_write_8", S_WRITE, 1'b0);
        tick();
        wr_end = 1'b0;
        expect_cycle("co_no_err", S_IDLE, 1'b0);
        tick();
        expect_cycle("co_no_err_2", S_IDLE, 1'b0);

        // Reset during a write grant.
        wr_req = 1'b1;
        expect_cycle("rst_req", S_IDLE, 1'b0);
        tick();
        wr_req = 1'b0;
        expect_cycle("rst_write", S_WRITE, 1'b0);
        tick();
        arb_rst = 1'b1;
        expect_cycle("rst_write_2", S_WRITE, 1'b0);
        tick();
        arb_rst = 1'b0;
        expect_cycle("rst_abort", S_INIT, 1'b0);
        tick();
        expect_cycle("rst_stay_init", S_INIT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1023: maximum number of cycles a granted client may hold the bus.
REQ-002 SHALL have port arb_clk, input, 1 bit: the single clock; all logic rises on its positive edge.
REQ-003 SHALL have port arb_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port init_end, input, 1: SDRAM power-up initialisation complete.
REQ-005 SHALL have ports init_cmd, input, 4; init_bank, input, 2; init_addr, input, 13: the initialisation command set, encoded {CS#,RAS#,CAS#,WE#}.
REQ-006 SHALL have ports ar_req, input, 1 and ar_end, input, 1: auto-refresh request and one-cycle completion pulse.
REQ-007 SHALL have ports ar_cmd, input, 4; ar_bank, input, 2; ar_addr, input, 13: the auto-refresh command set.
REQ-008 SHALL have ports wr_req, input, 1 and wr_end, input, 1, plus wr_cmd, input, 4; wr_bank, input, 2; wr_addr, input, 13: the write client.
REQ-009 SHALL have ports wr_dq, input, 16 and wr_dq_oe, input, 1: write data and its output enable.
REQ-010 SHALL have ports rd_req, input, 1 and rd_end, input, 1, plus rd_cmd, input, 4; rd_bank, input, 2; rd_addr, input, 13: the read client.
REQ-011 SHALL have ports ar_en, wr_en and rd_en, each output, 1: grants to the respective clients.
REQ-012 SHALL have ports sdram_cmd, output, 4; sdram_ba, output, 2; sdram_addr, output, 13: the multiplexed command bus to the SDRAM.
REQ-013 SHALL have ports sdram_dq_out, output, 16 and sdram_dq_oe, output, 1: the multiplexed data bus.
REQ-014 SHALL have port arb_err, output, 1: one-cycle pulse signalling a watchdog timeout.

Function
REQ-015 SHALL implement a registered FSM with states INIT, IDLE, AREF, WRITE and READ.
REQ-016 INIT -> IDLE when init_end=1; INIT SHALL be held otherwise.
REQ-017 From IDLE, the next state SHALL be chosen by fixed priority: ar_req -> AREF, else wr_req -> WRITE, else rd_req -> READ, else stay in IDLE.
REQ-018 AREF SHALL exit to IDLE on ar_end, WRITE on wr_end and READ on rd_end.
REQ-019 An end pulse from a non-granted client SHALL be ignored.
REQ-020 Every granted state SHALL return through IDLE for at least one cycle before a new grant; back-to-back grants are not permitted.
REQ-021 ar_en, wr_en and rd_en SHALL be combinational decodes of the current state: ar_en=(AREF), wr_en=(WRITE), rd_en=(READ).
- At most one grant SHALL be high in any cycle.
- Each grant SHALL rise in the cycle after the IDLE cycle in which its request was sampled.
REQ-022 The command bus SHALL be a combinational mux on the current state, with zero latency:
- INIT -> init_*
- AREF -> ar_*
- WRITE -> wr_*
- READ -> rd_*
- IDLE -> NOP 4'b0111, bank 2'b11, addr 13'h1fff
REQ-023 sdram_dq_out SHALL equal wr_dq and sdram_dq_oe SHALL equal wr_dq_oe only in WRITE; in all other states sdram_dq_oe=0 and sdram_dq_out=16'h0000.
REQ-024 A 16-bit watchdog counter SHALL clear in INIT and IDLE and increment each cycle in AREF, WRITE or READ.
REQ-025 When the watchdog equals TIMEOUT-1 without the matching end pulse, the FSM SHALL go to IDLE and arb_err SHALL pulse high for exactly 1 cycle (registered) in the following cycle.
REQ-026 If the end pulse and the timeout coincide, the end pulse SHALL win and arb_err SHALL remain 0.
REQ-027 Once IDLE has been reached, a deassertion of init_end SHALL NOT return the FSM to INIT.
REQ-028 Requests SHALL be level-sensitive: a request held high while another client is served SHALL be granted in the next IDLE cycle, in priority order.

Reset
REQ-029 When arb_rst=1 at a clock edge, the following SHALL hold on the next cycle:
- state INIT and watchdog 0
- ar_en, wr_en, rd_en and arb_err 0
- sdram_dq_oe 0
- sdram_cmd/ba/addr following the init_* inputs
REQ-030 Reset asserted in mid-grant SHALL abort the transaction immediately, without waiting for an end pulse.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- init_end=0 for 50 cycles with init_cmd=4'b0010 -> sdram_cmd=4'b0010 throughout and all grants 0; init_end=1 -> IDLE and sdram_cmd=4'b0111.
- ar_req, wr_req and rd_req all raised in the same IDLE cycle -> ar_en first; after ar_end -> one IDLE cycle, then wr_en; after wr_end -> IDLE, then rd_en.
- WRITE with wr_dq=16'hA5A5 and wr_dq_oe=1 -> sdram_dq_out=16'hA5A5 and sdram_dq_oe=1; in READ -> sdram_dq_oe=0.
- TIMEOUT=8, wr_req granted, wr_end never asserted -> wr_en high for 8 cycles, then IDLE and a one-cycle arb_err pulse.
- TIMEOUT=8 with wr_end on the 8th granted cycle -> normal exit and arb_err=0.
- ar_end pulsed while in READ -> ignored and rd_en stays high; arb_rst pulsed during WRITE -> next cycle in INIT with wr_en=0.
